// File: rtl/rtc_pkg.sv
// Shared widths, limits and mode codes for the time-of-day set controller.
// Also holds the wrap-around increment helpers used when editing fields.
package rtc_pkg;

  localparam int unsigned SEC_W  = 6;
  localparam int unsigned MIN_W  = 6;
  localparam int unsigned HR_W   = 5;
  localparam int unsigned MODE_W = 3;

  localparam logic [HR_W-1:0]  HR_MAX  = 5'd23;
  localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;

  localparam logic [MODE_W-1:0] RUN      = 3'd0;
  localparam logic [MODE_W-1:0] SET_HR   = 3'd1;
  localparam logic [MODE_W-1:0] SET_MIN  = 3'd2;
  localparam logic [MODE_W-1:0] SET_AHR  = 3'd3;
  localparam logic [MODE_W-1:0] SET_AMIN = 3'd4;

  // Raw values above the maximum are not clamped; they just count on and wrap.
  function automatic logic [HR_W-1:0] hr_inc(input logic [HR_W-1:0] v);
    return (v == HR_MAX) ? '0 : v + 1'b1;
  endfunction

  function automatic logic [MIN_W-1:0] min_inc(input logic [MIN_W-1:0] v);
    return (v == MIN_MAX) ? '0 : v + 1'b1;
  endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// Divides the system clock down to a single-cycle advance pulse.
// While hold_i is high the count is parked at zero and no pulse is issued.
module rtc_prescaler #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hold_i,
  output logic tick_o
);

  localparam int unsigned CntW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            at_max;

  assign at_max = (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q;
    if (hold_i) begin
      cnt_d = '0;
    end else if (at_max) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Gated by hold_i so a count caught mid-way on entering hold cannot fire.
  assign tick_o = at_max & ~hold_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rtc_set_ctrl.sv
// Time-of-day controller: advance pulse, button-driven time/alarm editing,
// counter load on leaving minute edit, and the alarm ringing flag.
module rtc_set_ctrl
  import rtc_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 50_000_000,
  parameter int unsigned RING_SECS = 60
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_mode,
  input  logic             btn_inc,
  input  logic             btn_stop,
  input  logic             alm_en_sw,
  input  logic [SEC_W-1:0] cur_sec,
  input  logic [MIN_W-1:0] cur_min,
  input  logic [HR_W-1:0]  cur_hr,
  output logic             tick,
  output logic             load,
  output logic [HR_W-1:0]  load_hr,
  output logic [MIN_W-1:0] load_min,
  output logic [HR_W-1:0]  alm_hr,
  output logic [MIN_W-1:0] alm_min,
  output logic [MODE_W-1:0] mode,
  output logic             ringing
);

  localparam int unsigned RingW = (RING_SECS > 1) ? $clog2(RING_SECS + 1) : 1;
  localparam logic [RingW-1:0] RingLast = RingW'(RING_SECS - 1);

  logic [MODE_W-1:0] mode_q, mode_d;
  logic [HR_W-1:0]   ed_hr_q, ed_hr_d;
  logic [MIN_W-1:0]  ed_min_q, ed_min_d;
  logic [HR_W-1:0]   alm_hr_q, alm_hr_d;
  logic [MIN_W-1:0]  alm_min_q, alm_min_d;
  logic              load_q, load_d;
  logic              tick_d_q;
  logic              ringing_q, ringing_d;
  logic [RingW-1:0]  ring_cnt_q, ring_cnt_d;

  logic frozen;
  logic enter_set;
  logic alarm_hit;
  logic ring_done;
  logic ring_clear;

  assign frozen = (mode_q == SET_HR) || (mode_q == SET_MIN);

  rtc_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold_i (frozen),
    .tick_o (tick)
  );

  // Mode sequencing and field editing; a mode press swallows a coincident inc.
  always_comb begin
    mode_d    = mode_q;
    ed_hr_d   = ed_hr_q;
    ed_min_d  = ed_min_q;
    alm_hr_d  = alm_hr_q;
    alm_min_d = alm_min_q;
    load_d    = 1'b0;
    if (btn_mode) begin
      case (mode_q)
        RUN: begin
          mode_d   = SET_HR;
          ed_hr_d  = cur_hr;
          ed_min_d = cur_min;
        end
        SET_HR:   mode_d = SET_MIN;
        SET_MIN: begin
          mode_d = SET_AHR;
          load_d = 1'b1;
        end
        SET_AHR:  mode_d = SET_AMIN;
        SET_AMIN: mode_d = RUN;
        default:  mode_d = RUN;
      endcase
    end else if (btn_inc) begin
      case (mode_q)
        SET_HR:   ed_hr_d   = hr_inc(ed_hr_q);
        SET_MIN:  ed_min_d  = min_inc(ed_min_q);
        SET_AHR:  alm_hr_d  = hr_inc(alm_hr_q);
        SET_AMIN: alm_min_d = min_inc(alm_min_q);
        default:  ;
      endcase
    end
  end

  // tick_d_q lines the compare up with the counter value the tick produced.
  assign alarm_hit = tick_d_q & alm_en_sw & ~frozen &
                     (cur_sec == '0) & (cur_min == alm_min_q) & (cur_hr == alm_hr_q);
  assign enter_set  = btn_mode & (mode_q == RUN);
  assign ring_done  = ringing_q & tick & (ring_cnt_q == RingLast);
  assign ring_clear = btn_stop | ~alm_en_sw | enter_set | ring_done;

  always_comb begin
    ringing_d  = ringing_q;
    ring_cnt_d = ring_cnt_q;
    if (ring_clear) begin
      ringing_d  = 1'b0;
      ring_cnt_d = '0;
    end else if (alarm_hit) begin
      ringing_d  = 1'b1;
      ring_cnt_d = '0;
    end else if (ringing_q && tick) begin
      ring_cnt_d = ring_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= RUN;
      ed_hr_q    <= '0;
      ed_min_q   <= '0;
      alm_hr_q   <= '0;
      alm_min_q  <= '0;
      load_q     <= 1'b0;
      tick_d_q   <= 1'b0;
      ringing_q  <= 1'b0;
      ring_cnt_q <= '0;
    end else begin
      mode_q     <= mode_d;
      ed_hr_q    <= ed_hr_d;
      ed_min_q   <= ed_min_d;
      alm_hr_q   <= alm_hr_d;
      alm_min_q  <= alm_min_d;
      load_q     <= load_d;
      tick_d_q   <= tick;
      ringing_q  <= ringing_d;
      ring_cnt_q <= ring_cnt_d;
    end
  end

  assign load     = load_q;
  assign load_hr  = ed_hr_q;
  assign load_min = ed_min_q;
  assign alm_hr   = alm_hr_q;
  assign alm_min  = alm_min_q;
  assign mode     = mode_q;
  assign ringing  = ringing_q;

endmodule

// File: tb/tb_rtc_set_ctrl.sv
// Bench for rtc_set_ctrl with a bench-owned h/m/s counter driven by tick and load.
// Load pulses are checked against a scoreboard queue filled when the edit is committed.
module tb_rtc_set_ctrl;

  logic       clk;
  logic       rst_n;
  logic       btn_mode, btn_inc, btn_stop, alm_en_sw;
  logic [5:0] c_sec, c_min;
  logic [4:0] c_hr;
  logic       tick, load, ringing;
  logic [4:0] load_hr, alm_hr;
  logic [5:0] load_min, alm_min;
  logic [2:0] mode;

  logic       preset_req;
  logic [4:0] p_hr;
  logic [5:0] p_min, p_sec;

  typedef struct {
    logic [4:0] hr;
    logic [5:0] min;
  } load_exp_t;
  load_exp_t exp_load_q[$];

  int n_checks;
  int n_fails;

  rtc_set_ctrl #(
    .TICK_DIV  (4),
    .RING_SECS (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .btn_stop  (btn_stop),
    .alm_en_sw (alm_en_sw),
    .cur_sec   (c_sec),
    .cur_min   (c_min),
    .cur_hr    (c_hr),
    .tick      (tick),
    .load      (load),
    .load_hr   (load_hr),
    .load_min  (load_min),
    .alm_hr    (alm_hr),
    .alm_min   (alm_min),
    .mode      (mode),
    .ringing   (ringing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Time-of-day counter model, not reset by rst_n.
  always @(posedge clk) begin
    if (preset_req) begin
      c_hr  <= p_hr;
      c_min <= p_min;
      c_sec <= p_sec;
    end else if (load) begin
      c_hr  <= load_hr;
      c_min <= load_min;
      c_sec <= 6'd0;
    end else if (tick) begin
      if (c_sec == 6'd59) begin
        c_sec <= 6'd0;
        if (c_min == 6'd59) begin
          c_min <= 6'd0;
          c_hr  <= (c_hr == 5'd23) ? 5'd0 : c_hr + 5'd1;
        end else begin
          c_min <= c_min + 6'd1;
        end
      end else begin
        c_sec <= c_sec + 6'd1;
      end
    end
  end

  task automatic check_value(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && load) begin
      if (exp_load_q.size() == 0) begin
        check_value("load_unexpected", 1, 0);
      end else begin
        load_exp_t e;
        e = exp_load_q.pop_front();
        check_value("load_hr", load_hr, e.hr);
        check_value("load_min", load_min, e.min);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && (mode == 3'd1 || mode == 3'd2)) check_value("tick_frozen", tick, 0);
  end

  // All tasks below are entered and left on a falling edge.
  task automatic press(input logic m, input logic i, input logic s);
    btn_mode = m;
    btn_inc  = i;
    btn_stop = s;
    @(negedge clk);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    btn_stop = 1'b0;
  endtask

  task automatic press_inc(input int n);
    for (int k = 0; k < n; k++) press(1'b0, 1'b1, 1'b0);
  endtask

  task automatic preset(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    p_hr = h;
    p_min = m;
    p_sec = s;
    preset_req = 1'b1;
    @(negedge clk);
    preset_req = 1'b0;
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    while (!tick && n < 16) begin
      @(negedge clk);
      n++;
    end
    check_value("tick_wait", tick, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0] snap_hr;
    logic [5:0] snap_min, snap_sec;
    n_checks = 0;
    n_fails  = 0;
    rst_n = 1'b0;
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    btn_stop = 1'b0;
    alm_en_sw = 1'b0;
    p_hr = 5'd0;
    p_min = 6'd0;
    p_sec = 6'd0;
    preset_req = 1'b1;

    // Reset state and tick cadence.
    repeat (3) @(negedge clk);
    check_value("rst_mode", mode, 0);
    check_value("rst_ringing", ringing, 0);
    check_value("rst_load", load, 0);
    check_value("rst_tick", tick, 0);
    check_value("rst_alm_hr", alm_hr, 0);
    check_value("rst_alm_min", alm_min, 0);
    check_value("rst_load_hr", load_hr, 0);
    preset_req = 1'b0;
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check_value("tick_period", tick, (k % 4 == 3) ? 1 : 0);
    end

    // Edit 10:20 to 13:05 and commit.
    preset(5'd10, 6'd20, 6'd0);
    press(1'b1, 1'b0, 1'b0);
    check_value("mode_set_hr", mode, 1);
    check_value("capture_hr", load_hr, 10);
    check_value("capture_min", load_min, 20);
    press_inc(3);
    check_value("ed_hr_13", load_hr, 13);
    press(1'b1, 1'b0, 1'b0);
    check_value("mode_set_min", mode, 2);
    press_inc(45);
    check_value("ed_min_wrap", load_min, 5);
    exp_load_q.push_back('{hr: 5'd13, min: 6'd5});
    press(1'b1, 1'b0, 1'b0);
    check_value("mode_set_ahr", mode, 3);
    check_value("load_pulse", load, 1);
    @(negedge clk);
    check_value("load_once", load, 0);
    check_value("cnt_hr_loaded", c_hr, 13);
    check_value("cnt_min_loaded", c_min, 5);
    check_value("cnt_sec_cleared", c_sec, 0);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    check_value("mode_back_run", mode, 0);

    // Hour wrap, mode+inc collision, then program the alarm to 07:00.
    preset(5'd23, 6'd0, 6'd0);
    press(1'b1, 1'b0, 1'b0);
    check_value("capture_hr_23", load_hr, 23);
    press_inc(1);
    check_value("ed_hr_wrap", load_hr, 0);
    press(1'b1, 1'b1, 1'b0);
    check_value("collide_mode", mode, 2);
    check_value("collide_hr", load_hr, 0);
    check_value("collide_min", load_min, 0);
    exp_load_q.push_back('{hr: 5'd0, min: 6'd0});
    press(1'b1, 1'b0, 1'b0);
    press_inc(7);
    press(1'b1, 1'b0, 1'b0);
    check_value("mode_set_amin", mode, 4);
    press(1'b1, 1'b0, 1'b0);
    check_value("alm_hr_7", alm_hr, 7);
    check_value("alm_min_0", alm_min, 0);
    check_value("mode_run_again", mode, 0);

    // Alarm rings two edges after the tick that rolls to 07:00:00, auto-clears.
    alm_en_sw = 1'b1;
    preset(5'd6, 6'd59, 6'd59);
    wait_tick();
    @(negedge clk);
    check_value("roll_hr", c_hr, 7);
    check_value("roll_min", c_min, 0);
    check_value("ring_not_yet", ringing, 0);
    @(negedge clk);
    check_value("ring_set", ringing, 1);
    repeat (9) @(negedge clk);
    check_value("ring_hold", ringing, 1);
    @(negedge clk);
    check_value("ring_third_tick", tick, 1);
    check_value("ring_hold_last", ringing, 1);
    @(negedge clk);
    check_value("ring_auto_clear", ringing, 0);

    // Stop while ringing, and stop coinciding with the match.
    preset(5'd6, 6'd59, 6'd59);
    wait_tick();
    repeat (2) @(negedge clk);
    check_value("ring_set2", ringing, 1);
    press(1'b0, 1'b0, 1'b1);
    check_value("ring_stopped", ringing, 0);
    preset(5'd6, 6'd59, 6'd59);
    wait_tick();
    @(negedge clk);
    press(1'b0, 1'b0, 1'b1);
    check_value("stop_beats_set", ringing, 0);
    @(negedge clk);
    check_value("stop_beats_set_after", ringing, 0);

    // Reset mid-edit drops the edit without touching the counter.
    preset(5'd12, 6'd34, 6'd56);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    check_value("mode_edit_min", mode, 2);
    snap_hr  = c_hr;
    snap_min = c_min;
    snap_sec = c_sec;
    rst_n = 1'b0;
    #1;
    check_value("midrst_mode", mode, 0);
    check_value("midrst_load", load, 0);
    check_value("midrst_alm_hr", alm_hr, 0);
    check_value("midrst_alm_min", alm_min, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_value("midrst_cnt_hr", c_hr, snap_hr);
    check_value("midrst_cnt_min", c_min, snap_min);
    check_value("midrst_cnt_sec", c_sec, snap_sec);
    check_value("midrst_mode_after", mode, 0);
    check_value("midrst_ed_hr", load_hr, 0);
    repeat (2) @(negedge clk);

    check_value("load_queue_empty", exp_load_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
